// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble and NOP/0 on invalid outputs.
// Optional feature macro PIPE_SKID_EN: two-entry skid storage with a registered in_ready_o.
//
// state    | meaning
// ST_EMPTY | no valid entry, outputs show the bubble (NOP_INST / 0 / 0)
// ST_ONE   | main entry valid and driving the outputs
// ST_TWO   | main and skid entries valid, upstream held off (skid build only)
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W = 64,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          inst_i,
  input  logic [31:0]          inst_addr_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          inst_o,
  output logic [31:0]          inst_addr_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 main_valid;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 load_main;
  logic [31:0]          main_inst_q;
  logic [31:0]          main_addr_q;
  logic [PAYLOAD_W-1:0] main_payload_q;

  assign main_valid  = (state_q != ST_EMPTY);
  assign out_valid_o = main_valid;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = main_valid & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_SKID_EN
  logic                 load_skid;
  logic                 main_from_skid;
  logic                 in_ready_q;
  logic [31:0]          skid_inst_q;
  logic [31:0]          skid_addr_q;
  logic [PAYLOAD_W-1:0] skid_payload_q;

  // Registered ready: no combinational path from out_ready_i to upstream.
  assign in_ready_o = in_ready_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (out_xfer && in_xfer) begin
            load_main = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d        = ST_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_inst_q    <= '0;
      skid_addr_q    <= '0;
      skid_payload_q <= '0;
    end else if (load_skid) begin
      skid_inst_q    <= inst_i;
      skid_addr_q    <= inst_addr_i;
      skid_payload_q <= payload_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_inst_q    <= '0;
      main_addr_q    <= '0;
      main_payload_q <= '0;
    end else if (load_main) begin
      if (main_from_skid) begin
        main_inst_q    <= skid_inst_q;
        main_addr_q    <= skid_addr_q;
        main_payload_q <= skid_payload_q;
      end else begin
        main_inst_q    <= inst_i;
        main_addr_q    <= inst_addr_i;
        main_payload_q <= payload_i;
      end
    end
  end
`else
  // Single entry: a downstream stall reaches upstream in the same cycle.
  assign in_ready_o = ~main_valid | out_ready_i;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer) begin
            load_main = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_inst_q    <= '0;
      main_addr_q    <= '0;
      main_payload_q <= '0;
    end else if (load_main) begin
      main_inst_q    <= inst_i;
      main_addr_q    <= inst_addr_i;
      main_payload_q <= payload_i;
    end
  end
`endif

  // Bubbles present a harmless NOP with no register write to the next stage.
  assign inst_o      = main_valid ? main_inst_q    : NOP_INST;
  assign inst_addr_o = main_valid ? main_addr_q    : 32'h0;
  assign payload_o   = main_valid ? main_payload_q : '0;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register carrying an instruction, its address and a stage-specific payload between adjacent stages of the core (IF→ID, ID→EX). It succeeds the fixed, always-advancing stage registers with a valid/ready handshake, a synchronous flush that converts the stage to a bubble, and an optional skid entry so that upstream ready is registered. Every stage boundary in the pipeline instantiates it, with a different `PAYLOAD_W`.

## Interface

Parameters:
- `PAYLOAD_W`, 64: width of the stage payload (operands, rd address, write enable, ...), ≥1.
- `NOP_INST`, 32'h0000_0013: instruction presented on `inst_o` when the stage holds no valid entry (`addi x0,x0,0`).

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `flush_i`, in, 1: synchronous flush; discards all held and incoming entries.
- `in_valid_i`, in, 1: upstream entry valid.
- `in_ready_o`, out, 1: stage can accept an entry.
- `inst_i`, in, 32: upstream instruction.
- `inst_addr_i`, in, 32: upstream instruction address.
- `payload_i`, in, `PAYLOAD_W`: upstream payload.
- `out_valid_o`, out, 1: downstream entry valid.
- `out_ready_i`, in, 1: downstream accepts the entry.
- `inst_o`, out, 32: held instruction, or `NOP_INST` when invalid.
- `inst_addr_o`, out, 32: held instruction address, or 0 when invalid.
- `payload_o`, out, `PAYLOAD_W`: held payload, or 0 when invalid.

## Operation

- Input transfer: `in_valid_i & in_ready_o` at the edge. Output transfer: `out_valid_o & out_ready_i` at the edge.
- Storage: a main entry that drives the outputs, plus a skid entry when `PIPE_SKID_EN` is defined.
- States (skid build): EMPTY (neither entry valid), ONE (main valid), TWO (main and skid valid).
  - EMPTY + input transfer → ONE, with the input in main.
  - ONE + output transfer + input transfer → ONE, with main replaced by the input.
  - ONE + output transfer only → EMPTY.
  - ONE + input transfer only → TWO, with the input in skid.
  - TWO + output transfer → ONE, with skid moved to main. No input transfer is possible in TWO because `in_ready_o` is 0.
  - All other combinations hold state.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush: `flush_i`=1 at an edge forces EMPTY. A simultaneous input transfer is discarded, and a simultaneous output transfer still counts as consumed downstream. Flush wins over every other event.
- Reset:
  - `out_valid_o`=0, `in_ready_o`=1, `inst_o`=`NOP_INST`, `inst_addr_o`=0, `payload_o`=0.
  - Stored data registers are cleared to 0.
  - Nothing is captured while `rst` is high.
  - Reset asserted mid-transfer discards both entries immediately, without waiting for a clock edge.
- Invalid outputs are forced (NOP/0) so that downstream decode sees a harmless instruction with no register write.

## Timing

- Latency: an input accepted at edge N appears on the outputs with `out_valid_o`=1 after edge N.
- Throughput: one entry per cycle while `out_ready_i`=1, in both builds.
- Skid build:
  - `in_ready_o` is a register equal to NOT(skid valid) and has no combinational path from `out_ready_i`.
  - `in_ready_o` falls the cycle after entering TWO and rises the cycle after leaving it.
- Non-skid build: `in_ready_o` = `~out_valid_o | out_ready_i`, combinationally.
- Under flush in either build, `out_valid_o`=0 from the cycle after the flush edge, and `in_ready_o`=1.

## Configuration

- `PIPE_SKID_EN` defined:
  - Two-entry storage as described above, with registered `in_ready_o`.
  - Upstream may observe `in_ready_o`=1 for one cycle after downstream stalls; that entry lands in skid.
- `PIPE_SKID_EN` undefined:
  - Main entry only, states EMPTY/ONE.
  - `in_ready_o` is combinational from `out_ready_i`, so a stall propagates upstream in the same cycle.
  - Behaviour at the ports is otherwise identical.

## Test plan

- Reset then stream: stream 8 entries (`inst_i`=32'h0010_0093+k, `inst_addr_i`=4k) with `out_ready_i`=1. Required: outputs lag by one cycle, identical order, `out_valid_o` continuous, no bubbles.
- Downstream stall (skid build): send entries A and B with `out_ready_i`=0 from the cycle A is accepted. Required: A is held on the outputs, B is captured in skid, and `in_ready_o`=0 the next cycle. On `out_ready_i`=1, A then B leave on consecutive cycles and `in_ready_o` returns to 1.
- Same stall, non-skid build: required `in_ready_o`=0 in the same cycle `out_ready_i` falls while the stage is full, and B is not accepted.
- Flush in state TWO with a simultaneous `in_valid_i`=1:
  - Next cycle: `out_valid_o`=0, `inst_o`=32'h0000_0013, `inst_addr_o`=0, `payload_o`=0, `in_ready_o`=1.
  - The incoming entry never appears on the outputs.
- Asynchronous reset mid-operation: assert `rst` between edges while in state ONE. Required: `out_valid_o` and the data outputs go to their reset values immediately, before the next edge.
- `PAYLOAD_W`=1 and `PAYLOAD_W`=128: walking-ones payload is passed through bit-exact.
